// File: rtl/camellia_feistel6.sv
// camellia_feistel6: iterative Camellia Feistel rounds over a 128-bit state, feeding the FL/FL^-1 layer.
// Latency: out_valid rises NUM_ROUNDS+1 cycles after the accept cycle (NUM_ROUNDS/2+1 with unroll).
// Backpressure: one block in flight; in_ready low in RUN/DONE, result held in DONE until out_ready.
//
// Ports:
//   clk, RST          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready input handshake; in_state = {L0, R0}, in_keys = {k1 .. kN} (k1 in top 64 bits)
//   out_valid/out_ready output handshake; out_state = {L_N, R_N}
//   busy              high while a block is in RUN or DONE
//
// Optional build macro CAMELLIA_FEISTEL_UNROLL2_EN: two chained F stages, two rounds per RUN cycle.
// NUM_ROUNDS must be even, 2..6.

module camellia_feistel6 #(
  parameter int NUM_ROUNDS = 6
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [127:0]             in_state,
  input  logic [64*NUM_ROUNDS-1:0] in_keys,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [127:0]             out_state,
  output logic                     busy
);

  localparam int KW    = 64 * NUM_ROUNDS;
`ifdef CAMELLIA_FEISTEL_UNROLL2_EN
  localparam int RPC   = 2;  // rounds per RUN cycle
`else
  localparam int RPC   = 1;
`endif
  localparam int CNT_W = $clog2(NUM_ROUNDS + 1);

  // Camellia s1 substitution table.
  localparam logic [7:0] S1_TAB [256] = '{
    112,130, 44,236,179, 39,192,229,228,133, 87, 53,234, 12,174, 65,
     35,239,107,147, 69, 25,165, 33,237, 14, 79, 78, 29,101,146,189,
    134,184,175,143,124,235, 31,206, 62, 48,220, 95, 94,197, 11, 26,
    166,225, 57,202,213, 71, 93, 61,217,  1, 90,214, 81, 86,108, 77,
    139, 13,154,102,251,204,176, 45,116, 18, 43, 32,240,177,132,153,
    223, 76,203,194, 52,126,118,  5,109,183,169, 49,209, 23,  4,215,
     20, 88, 58, 97,222, 27, 17, 28, 50, 15,156, 22, 83, 24,242, 34,
    254, 68,207,178,195,181,122,145, 36,  8,232,168, 96,252,105, 80,
    170,208,160,125,161,137, 98,151, 84, 91, 30,149,224,255,100,210,
     16,196,  0, 72,163,247,117,219,138,  3,230,218,  9, 63,221,148,
    135, 92,131,  2,205, 74,144, 51,115,103,246,243,157,127,191,226,
     82,155,216, 38,200, 55,198, 59,129,150,111, 75, 19,190, 99, 46,
    233,121,167,140,159,110,188,142, 41,245,249,182, 47,253,180, 89,
    120,152,  6,106,231, 70,113,186,212, 37,171, 66,136,162,141,250,
    114,  7,185, 85,248,238,172, 10, 54, 73, 42,104, 60, 56,241,164,
     64, 40,211,123,187,201, 67,193, 21,227,173,244,119,199,128,158
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic logic [7:0] rol1(input logic [7:0] a);
    return {a[6:0], a[7]};
  endfunction

  function automatic logic [7:0] ror1(input logic [7:0] a);
    return {a[0], a[7:1]};
  endfunction

  function automatic logic [7:0] sb1(input logic [7:0] a);
    return S1_TAB[a];
  endfunction

  // Camellia F: key mix, S-layer (s1,s2,s3,s4,s2,s3,s4,s1), then the P byte-mixing layer.
  function automatic logic [63:0] f_func(input logic [63:0] x, input logic [63:0] k);
    logic [63:0] t;
    logic [7:0]  u1, u2, u3, u4, u5, u6, u7, u8;
    logic [7:0]  y1, y2, y3, y4, y5, y6, y7, y8;
    t  = x ^ k;
    u1 = sb1(t[63:56]);
    u2 = rol1(sb1(t[55:48]));
    u3 = ror1(sb1(t[47:40]));
    u4 = sb1(rol1(t[39:32]));
    u5 = rol1(sb1(t[31:24]));
    u6 = ror1(sb1(t[23:16]));
    u7 = sb1(rol1(t[15:8]));
    u8 = sb1(t[7:0]);
    y1 = u1 ^ u3 ^ u4 ^ u6 ^ u7 ^ u8;
    y2 = u1 ^ u2 ^ u4 ^ u5 ^ u7 ^ u8;
    y3 = u1 ^ u2 ^ u3 ^ u5 ^ u6 ^ u8;
    y4 = u2 ^ u3 ^ u4 ^ u5 ^ u6 ^ u7;
    y5 = u1 ^ u2 ^ u6 ^ u7 ^ u8;
    y6 = u2 ^ u3 ^ u5 ^ u7 ^ u8;
    y7 = u3 ^ u4 ^ u5 ^ u6 ^ u8;
    y8 = u1 ^ u4 ^ u5 ^ u6 ^ u7;
    return {y1, y2, y3, y4, y5, y6, y7, y8};
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [63:0]      l_q,     l_d;
  logic [63:0]      r_q,     r_d;
  logic [KW-1:0]    key_q,   key_d;
  logic [127:0]     out_q,   out_d;

  // Round datapath: L' = R ^ F(L, k), R' = L. The current subkey is always the top word.
  logic [63:0] l_a, r_a, l_nxt, r_nxt;

  assign l_a = r_q ^ f_func(l_q, key_q[KW-1 -: 64]);
  assign r_a = l_q;

`ifdef CAMELLIA_FEISTEL_UNROLL2_EN
  assign l_nxt = r_a ^ f_func(l_a, key_q[KW-65 -: 64]);
  assign r_nxt = l_a;
`else
  assign l_nxt = l_a;
  assign r_nxt = r_a;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    key_d   = key_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          l_d     = in_state[127:64];
          r_d     = in_state[63:0];
          key_d   = in_keys;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        l_d   = l_nxt;
        r_d   = r_nxt;
        key_d = key_q << (64 * RPC);
        cnt_d = cnt_q + CNT_W'(RPC);
        // Last round: register the result straight into the output so DONE presents it next cycle.
        if (cnt_q == CNT_W'(NUM_ROUNDS - RPC)) begin
          out_d   = {l_nxt, r_nxt};
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      key_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      key_q   <= key_d;
      out_q   <= out_d;
    end
  end

  // IDLE is also the reset state, so in_ready is masked while reset is held.
  assign in_ready  = (state_q == IDLE) && !RST;
  assign out_valid = (state_q == DONE);
  assign out_state = out_q;
  assign busy      = (state_q != IDLE);

endmodule
